// File: rtl/toggle_counter.sv
// toggle_counter: WIDTH-bit register bank built from per-bit toggle stages.
// Acts as a T-register (mode 00), up counter (01), down counter (10) or
// parallel-load register (11). q and ovf are registered; tc is combinational
// from q and mode so stages can be cascaded with tc & en as a carry-enable.
module toggle_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] up_mask, dn_mask, t_mask;
    logic             at_max, at_min;

    assign at_max = &q_q;
    assign at_min = ~|q_q;

    // Counting toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic up_run;
        logic dn_run;
        up_run  = 1'b1;
        dn_run  = 1'b1;
        up_mask = '0;
        dn_mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            up_mask[i] = up_run;
            dn_mask[i] = dn_run;
            up_run     = up_run & q_q[i];
            dn_run     = dn_run & ~q_q[i];
        end
    end

    // Select the toggle mask for the sampled mode; a saturated hold toggles nothing.
    always_comb begin
        t_mask = '0;
        ovf_d  = 1'b0;
        if (en) begin
            case (mode)
                MODE_TOGGLE: t_mask = t_in;
                MODE_UP: begin
                    t_mask = up_mask;
                    if (at_max) begin
                        ovf_d = 1'b1;
                        if (SATURATE) t_mask = '0;
                    end
                end
                MODE_DOWN: begin
                    t_mask = dn_mask;
                    if (at_min) begin
                        ovf_d = 1'b1;
                        if (SATURATE) t_mask = '0;
                    end
                end
                default: t_mask = '0;
            endcase
        end
        q_d = q_q ^ t_mask;
        if (en && (mode == MODE_LOAD)) q_d = d_in;
    end

    // State register; reset forces RESET_VAL and clears the overflow pulse immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RESET_VAL;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
    assign tc  = ((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_min);

endmodule
